// File: rtl/card_pkg.sv
//==============================================================================
// Module : card_pkg
// Brief  : Deck constants, card field layout and index-to-card conversion.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package card_pkg;

    localparam int NUM_CARDS = 52;
    localparam int NUM_RANKS = 13;

    localparam int SUIT_MSB = 5;
    localparam int SUIT_LSB = 4;
    localparam int RANK_MSB = 3;
    localparam int RANK_LSB = 0;

    localparam logic [5:0] CARD_NONE = 6'd0;

    typedef logic [5:0] card_t;
    typedef logic [5:0] idx_t;

    // Deck index 0..51 -> {suit, rank}; suit = idx/13, rank = idx%13 + 1.
    function automatic card_t idx_to_card(input idx_t idx);
        card_t c;
        if (idx >= 6'd39) begin
            c[SUIT_MSB:SUIT_LSB] = 2'd3;
            c[RANK_MSB:RANK_LSB] = 4'(idx - 6'd38);
        end else if (idx >= 6'd26) begin
            c[SUIT_MSB:SUIT_LSB] = 2'd2;
            c[RANK_MSB:RANK_LSB] = 4'(idx - 6'd25);
        end else if (idx >= 6'd13) begin
            c[SUIT_MSB:SUIT_LSB] = 2'd1;
            c[RANK_MSB:RANK_LSB] = 4'(idx - 6'd12);
        end else begin
            c[SUIT_MSB:SUIT_LSB] = 2'd0;
            c[RANK_MSB:RANK_LSB] = 4'(idx + 6'd1);
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr16.sv
//==============================================================================
// Module : lfsr16
// Brief  : Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= seed;
        end else begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/card_dealer.sv
//==============================================================================
// Module : card_dealer
// Brief  : Deals pseudo-random cards from a 52-card deck without replacement.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module card_dealer
    import card_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shuffle,
    input  logic       deal_req,
    output logic [5:0] card,
    output logic       deal_valid,
    output logic       deal_err,
    output logic       busy,
    output logic [5:0] cards_left
);

    localparam logic [5:0] c_FULL_DECK = 6'(NUM_CARDS);
    localparam logic [5:0] c_LAST_IDX  = 6'(NUM_CARDS - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SEARCH = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [51:0] r_used, w_used_nxt;
    idx_t        r_idx, w_idx_nxt;
    card_t       w_card_nxt;
    logic [5:0]  w_left_nxt;
    logic        w_valid_nxt, w_err_nxt, w_busy_nxt;
    logic [15:0] w_lfsr;
    idx_t        w_start;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (w_lfsr)
    );

    // Only the low six bits seed the probe start; the rest only feed back.
    logic w_lfsr_unused;
    assign w_lfsr_unused = ^w_lfsr[15:6];

    assign w_start = (w_lfsr[5:0] >= c_FULL_DECK) ? (w_lfsr[5:0] - c_FULL_DECK)
                                                  : w_lfsr[5:0];

    always_comb begin
        w_state_nxt = r_state;
        w_used_nxt  = r_used;
        w_idx_nxt   = r_idx;
        w_card_nxt  = card;
        w_left_nxt  = cards_left;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_busy_nxt  = busy;

        if (shuffle) begin
            w_used_nxt  = '0;
            w_left_nxt  = c_FULL_DECK;
            w_card_nxt  = CARD_NONE;
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (deal_req) begin
                        if (cards_left != 6'd0) begin
                            w_idx_nxt   = w_start;
                            w_busy_nxt  = 1'b1;
                            w_state_nxt = ST_SEARCH;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                ST_SEARCH: begin
                    // Linear probe; entry guarantees at least one free slot.
                    if (!r_used[r_idx]) begin
                        w_used_nxt[r_idx] = 1'b1;
                        w_card_nxt        = idx_to_card(r_idx);
                        w_valid_nxt       = 1'b1;
                        w_left_nxt        = cards_left - 6'd1;
                        w_busy_nxt        = 1'b0;
                        w_state_nxt       = ST_IDLE;
                    end else begin
                        w_idx_nxt = (r_idx == c_LAST_IDX) ? 6'd0 : r_idx + 6'd1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_used     <= '0;
            r_idx      <= '0;
            card       <= CARD_NONE;
            deal_valid <= 1'b0;
            deal_err   <= 1'b0;
            busy       <= 1'b0;
            cards_left <= c_FULL_DECK;
        end else begin
            r_state    <= w_state_nxt;
            r_used     <= w_used_nxt;
            r_idx      <= w_idx_nxt;
            card       <= w_card_nxt;
            deal_valid <= w_valid_nxt;
            deal_err   <= w_err_nxt;
            busy       <= w_busy_nxt;
            cards_left <= w_left_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: a reference LFSR and deck model predict
// every dealt card and its latency.
`default_nettype none

module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       shuffle = 1'b0;
    logic       deal_req = 1'b0;
    logic [5:0] card;
    logic       deal_valid;
    logic       deal_err;
    logic       busy;
    logic [5:0] cards_left;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] m_lfsr;
    logic [51:0] m_used;
    int          m_left;
    logic [5:0]  m_card;

    always #5 clk = ~clk;

    card_dealer #(.LFSR_SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst        (rst),
        .shuffle    (shuffle),
        .deal_req   (deal_req),
        .card       (card),
        .deal_valid (deal_valid),
        .deal_err   (deal_err),
        .busy       (busy),
        .cards_left (cards_left)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk) m_lfsr <= (!rst) ? 16'hACE1 : lfsr_step(m_lfsr);

    function automatic logic [5:0] exp_code(input int i);
        logic [1:0] s;
        logic [3:0] r;
        s = 2'(i / 13);
        r = 4'((i % 13) + 1);
        return {s, r};
    endfunction

    function automatic void predict(input int s, input logic [51:0] used,
                                    output int fin, output int probes);
        int i;
        i = s;
        probes = 1;
        while (used[i] && probes < 53) begin
            i = (i == 51) ? 0 : i + 1;
            probes++;
        end
        fin = i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_used = '0;
        m_left = 52;
        m_card = 6'd0;
    endtask

    // Issue one deal when the model LFSR satisfies the requested start
    // condition; deal_req is held for 'hold' edges. Returns measured latency.
    task automatic do_deal(input int hold, input bit avoid_zero,
                           input int want_start, output int lat);
        int  s, fin, probes, waited;
        bit  got, saw_err;
        waited = 0;
        lat = 0;
        s = 0; fin = 0; probes = 0;
        while (waited < 2000) begin
            s = int'(m_lfsr[5:0]);
            if (s >= 52) s -= 52;
            predict(s, m_used, fin, probes);
            if ((!avoid_zero || fin != 0) && (want_start < 0 || s == want_start)) break;
            tick();
            waited++;
        end
        if (waited >= 2000) begin
            n_vec++; n_bad++;
            $display("FAIL deal_setup: no suitable LFSR state within 2000 cycles (want_start=%0d)", want_start);
            return;
        end
        deal_req = 1'b1;
        tick();
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL busy_rise: busy=%b expected 1", busy);
        end
        lat = 1;
        got = 1'b0;
        saw_err = 1'b0;
        while (lat < hold) begin
            if (deal_valid === 1'b1) got = 1'b1;
            tick();
            lat++;
        end
        deal_req = 1'b0;
        while (!got && lat < 60) begin
            if (deal_err === 1'b1) saw_err = 1'b1;
            if (deal_valid === 1'b1) got = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        n_vec++;
        if (!got || saw_err) begin
            n_bad++;
            $display("FAIL deal_wait: got_valid=%b saw_err=%b after %0d cycles", got, saw_err, lat);
            return;
        end
        m_used[fin] = 1'b1;
        m_left--;
        m_card = exp_code(fin);
        n_vec++;
        if (lat != probes + 1) begin
            n_bad++; $display("FAIL deal_latency: %0d cycles expected %0d", lat, probes + 1);
        end
        n_vec++;
        if (card !== m_card) begin
            n_bad++; $display("FAIL deal_card: card=%h expected %h (idx %0d)", card, m_card, fin);
        end
        n_vec++;
        if (cards_left !== 6'(m_left) || busy !== 1'b0) begin
            n_bad++; $display("FAIL deal_state: cards_left=%0d busy=%b expected %0d 0", cards_left, busy, m_left);
        end
        tick();
        n_vec++;
        if (deal_valid !== 1'b0) begin
            n_bad++; $display("FAIL deal_pulse: deal_valid=%b expected 0", deal_valid);
        end
    endtask

    task automatic check_cleared(input string tag);
        n_vec++;
        if (card !== 6'd0 || cards_left !== 6'd52 || busy !== 1'b0 ||
            deal_valid !== 1'b0 || deal_err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: card=%h left=%0d busy=%b dv=%b de=%b expected 00 52 0 0 0",
                     tag, card, cards_left, busy, deal_valid, deal_err);
        end
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (deal_valid === 1'b1 || deal_err === 1'b1) hits++;
        end
        n_vec++;
        if (hits != 0) begin
            n_bad++; $display("FAIL %s: %0d unexpected pulses, expected 0", tag, hits);
        end
    endtask

    task automatic do_shuffle();
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        model_clear();
        check_cleared("shuffle");
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        check_cleared("reset");
        rst = 1'b1;
        model_clear();
        tick();
        check_cleared("reset_release");
    endtask

    task automatic test_full_deck();
        int  lat;
        bit  seen [64];
        int  bad_rank, dup;
        bad_rank = 0;
        dup = 0;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int n = 0; n < 52; n++) begin
            do_deal(1, 1'b0, -1, lat);
            if (card[3:0] < 4'd1 || card[3:0] > 4'd13) bad_rank++;
            if (seen[card]) dup++;
            seen[card] = 1'b1;
            n_vec++;
            if (lat < 2 || lat > 53) begin
                n_bad++; $display("FAIL latency_range: %0d not in 2..53", lat);
            end
        end
        n_vec++;
        if (bad_rank != 0 || dup != 0) begin
            n_bad++; $display("FAIL deck_distinct: bad_rank=%0d duplicates=%0d expected 0 0", bad_rank, dup);
        end
        n_vec++;
        if (cards_left !== 6'd0) begin
            n_bad++; $display("FAIL deck_empty: cards_left=%0d expected 0", cards_left);
        end
    endtask

    task automatic test_empty_deck();
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        n_vec++;
        if (deal_err !== 1'b1 || deal_valid !== 1'b0 || card !== m_card || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_err: de=%b dv=%b card=%h busy=%b expected 1 0 %h 0",
                     deal_err, deal_valid, card, busy, m_card);
        end
        tick();
        n_vec++;
        if (deal_err !== 1'b0 || card !== m_card || cards_left !== 6'd0) begin
            n_bad++; $display("FAIL empty_after: de=%b card=%h left=%0d expected 0 %h 0",
                              deal_err, card, cards_left, m_card);
        end
        watch_quiet("empty_quiet", 10);
    endtask

    task automatic test_probe_wrap();
        int lat;
        do_shuffle();
        for (int n = 0; n < 51; n++) do_deal(1, 1'b1, -1, lat);
        do_deal(1, 1'b0, 51, lat);
        n_vec++;
        if (card !== 6'h01 || lat != 3) begin
            n_bad++; $display("FAIL probe_wrap: card=%h latency=%0d expected 01 3", card, lat);
        end
    endtask

    task automatic test_shuffle_mid_search();
        int lat;
        do_shuffle();
        for (int n = 0; n < 3; n++) do_deal(1, 1'b0, -1, lat);
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++; $display("FAIL abort_busy: busy=%b expected 1", busy);
        end
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        model_clear();
        check_cleared("abort_shuffle");
        watch_quiet("abort_quiet", 60);
    endtask

    task automatic test_reset_mid_search();
        int lat;
        do_deal(1, 1'b0, -1, lat);
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_clear();
        check_cleared("abort_reset");
        watch_quiet("reset_quiet", 5);
        for (int n = 0; n < 3; n++) do_deal(1, 1'b0, -1, lat);
    endtask

    task automatic test_collisions();
        int lat;
        do_deal(1, 1'b0, -1, lat);
        do_deal(1, 1'b0, -1, lat);
        deal_req = 1'b1;
        shuffle  = 1'b1;
        tick();
        deal_req = 1'b0;
        shuffle  = 1'b0;
        model_clear();
        check_cleared("req_and_shuffle");
        watch_quiet("dropped_req", 60);
        do_deal(2, 1'b0, -1, lat);
        watch_quiet("req_while_busy", 60);
        n_vec++;
        if (cards_left !== 6'(m_left)) begin
            n_bad++; $display("FAIL busy_ignore: cards_left=%0d expected %0d", cards_left, m_left);
        end
    endtask

    always @(negedge clk) begin
        if (rst && deal_valid === 1'b1 && deal_err === 1'b1) begin
            n_vec++; n_bad++;
            $display("FAIL pulse_exclusive: deal_valid and deal_err both high");
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_deck();
        test_empty_deck();
        test_probe_wrap();
        test_shuffle_mid_search();
        test_reset_mid_search();
        test_collisions();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
